// File: rtl/std_pkg.sv
// Shared types for the std_* register library: clock description and
// masked read-modify-write opcodes.
package std_pkg;

  typedef struct packed {
    logic [31:0] freq_khz;
    logic [7:0]  duty_pct;
  } std_clock_info_t;

  typedef enum logic [1:0] {
    STD_MASK_OP_WRITE  = 2'd0,
    STD_MASK_OP_SET    = 2'd1,
    STD_MASK_OP_CLEAR  = 2'd2,
    STD_MASK_OP_TOGGLE = 2'd3
  } std_mask_op_t;

  function automatic int unsigned std_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/std_register_granular.sv
// Register of type T with an independent write enable per bit.
module std_register_granular
  import std_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO   = '0,
  parameter type             T            = logic,
  parameter T                RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [$bits(T)-1:0] enable,
  input  logic [$bits(T)-1:0] next,
  output T                    value
);

  localparam int unsigned W = $bits(T);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VECTOR;
    end else begin
      for (int unsigned k = 0; k < W; k++) begin
        if (enable[k]) q[k] <= next[k];
      end
    end
  end

  assign value = T'(q);

endmodule

// File: rtl/std_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant searched circularly from a pointer that
// moves just past the winner whenever the grant is consumed.
module std_round_robin_arbiter
  import std_pkg::*;
#(
  parameter  int unsigned PORTS = 2,
  localparam int unsigned ID_W  = std_id_width(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic             advance,
  output logic [PORTS-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      cand = ID_W'((32'(ptr) + o) % PORTS);
      if (!found && request[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (32'(grant_id) == PORTS - 1) ptr <= '0;
      else                            ptr <= grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/std_register_granular_arbiter.sv
// Shared bit-granular register: PORTS requesters issue masked RMW operations,
// one is served per cycle and old/new values come back on one response channel.
module std_register_granular_arbiter
  import std_pkg::*;
#(
  parameter  std_clock_info_t CLOCK_INFO   = '0,
  parameter  type             T            = logic,
  parameter  T                RESET_VECTOR = '0,
  parameter  int unsigned     PORTS        = 2,
  localparam int unsigned     ID_W         = std_id_width(PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               req_valid,
  output logic [PORTS-1:0]               req_ready,
  input  logic [PORTS-1:0][1:0]          req_op,
  input  logic [PORTS-1:0][$bits(T)-1:0] req_mask,
  input  logic [PORTS-1:0][$bits(T)-1:0] req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [$bits(T)-1:0]            rsp_old,
  output logic [$bits(T)-1:0]            rsp_new,
  output logic [$bits(T)-1:0]            value
);

  localparam int unsigned W = $bits(T);

  logic [PORTS-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             can_issue;
  logic             fire;
  std_mask_op_t     op;
  logic [W-1:0]     op_mask;
  logic [W-1:0]     op_data;
  logic [W-1:0]     enable;
  logic [W-1:0]     next;
  logic [W-1:0]     updated;
  T                 stored;

  std_round_robin_arbiter #(
    .PORTS (PORTS)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .request  (req_valid),
    .advance  (fire),
    .grant    (grant),
    .grant_id (grant_id)
  );

  std_register_granular #(
    .CLOCK_INFO   (CLOCK_INFO),
    .T            (T),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .next   (next),
    .value  (stored)
  );

  assign value = W'(stored);

  // A free response slot is either empty or being drained this cycle.
  always_comb begin
    can_issue = !rsp_valid || rsp_ready;
    req_ready = grant & {PORTS{can_issue}};
    fire      = |(req_valid & req_ready);
  end

  always_comb begin
    op      = std_mask_op_t'(req_op[grant_id]);
    op_mask = req_mask[grant_id];
    op_data = req_data[grant_id];
    enable  = fire ? op_mask : '0;
    next    = value;
    case (op)
      STD_MASK_OP_WRITE:  next = op_data;
      STD_MASK_OP_SET:    next = '1;
      STD_MASK_OP_CLEAR:  next = '0;
      STD_MASK_OP_TOGGLE: next = ~value;
      default:            next = value;
    endcase
    updated = (value & ~enable) | (next & enable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_old   <= '0;
      rsp_new   <= '0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_id;
      rsp_old   <= value;
      rsp_new   <= updated;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_std_register_granular_arbiter.sv
// Directed bench for std_register_granular_arbiter: 8-bit word, 3 ports,
// reset vector A5.
module tb_std_register_granular_arbiter;
  import std_pkg::*;

  logic            clk;
  logic            rst;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [2:0][1:0] req_op;
  logic [2:0][7:0] req_mask;
  logic [2:0][7:0] req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_old;
  logic [7:0]      rsp_new;
  logic [7:0]      value;

  int checks = 0;
  int errors = 0;

  std_register_granular_arbiter #(
    .CLOCK_INFO   ('0),
    .T            (logic [7:0]),
    .RESET_VECTOR (8'hA5),
    .PORTS        (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_old   (rsp_old),
    .rsp_new   (rsp_new),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input std_mask_op_t op, input logic [7:0] mask,
                         input logic [7:0] data);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_mask[p]  = mask;
    req_data[p]  = data;
  endtask

  task automatic idle();
    req_valid = '0;
    req_op    = '0;
    req_mask  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] exp_val [3];
  logic [7:0] exp_old [3];

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_value", value, 8'hA5);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_old", rsp_old, 0);
    check("rst_rsp_new", rsp_new, 0);
    check("rst_req_ready", req_ready, 0);

    // single WRITE from port 1
    set_req(1, STD_MASK_OP_WRITE, 8'hF0, 8'h3C);
    rsp_ready = 1'b1;
    #1;
    check("wr_req_ready", req_ready, 3'b010);
    tick();
    idle();
    #1;
    check("wr_value", value, 8'h35);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_id", rsp_id, 1);
    check("wr_rsp_old", rsp_old, 8'hA5);
    check("wr_rsp_new", rsp_new, 8'h35);
    tick();
    check("wr_rsp_drain", rsp_valid, 0);
    check("wr_value_hold", value, 8'h35);

    // round robin over three SET requests
    do_reset();
    set_req(0, STD_MASK_OP_SET, 8'h01, 8'h00);
    set_req(1, STD_MASK_OP_SET, 8'h02, 8'h00);
    set_req(2, STD_MASK_OP_SET, 8'h04, 8'h00);
    rsp_ready = 1'b1;
    exp_val = '{8'hA5, 8'hA7, 8'hA7};
    exp_old = '{8'hA5, 8'hA5, 8'hA7};
    check("rr_value0", value, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rr_req_ready%0d", i), req_ready, 32'(1) << i);
      tick();
      check($sformatf("rr_rsp_id%0d", i), rsp_id, i);
      check($sformatf("rr_rsp_old%0d", i), rsp_old, exp_old[i]);
      check($sformatf("rr_rsp_new%0d", i), rsp_new, exp_val[i]);
      check($sformatf("rr_value%0d", i + 1), value, exp_val[i]);
    end

    // back-pressure on the response channel
    do_reset();
    set_req(0, STD_MASK_OP_TOGGLE, 8'hFF, 8'h00);
    set_req(1, STD_MASK_OP_SET, 8'h80, 8'h00);
    rsp_ready = 1'b0;
    #1;
    check("bp_req_ready_first", req_ready, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("bp_value", value, 8'h5A);
    check("bp_rsp_id", rsp_id, 0);
    check("bp_req_ready_stall", req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), rsp_valid, 1);
      check($sformatf("bp_hold_old%0d", i), rsp_old, 8'hA5);
      check($sformatf("bp_hold_new%0d", i), rsp_new, 8'h5A);
      check($sformatf("bp_hold_ready%0d", i), req_ready, 0);
      check($sformatf("bp_hold_value%0d", i), value, 8'h5A);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 3'b010);
    tick();
    req_valid[1] = 1'b0;
    #1;
    check("bp_next_valid", rsp_valid, 1);
    check("bp_next_id", rsp_id, 1);
    check("bp_next_old", rsp_old, 8'h5A);
    check("bp_next_new", rsp_new, 8'hDA);
    check("bp_next_value", value, 8'hDA);

    // zero-mask CLEAR from port 2
    set_req(2, STD_MASK_OP_CLEAR, 8'h00, 8'hFF);
    #1;
    check("zm_req_ready", req_ready, 3'b100);
    tick();
    req_valid[2] = 1'b0;
    #1;
    check("zm_rsp_id", rsp_id, 2);
    check("zm_rsp_old", rsp_old, 8'hDA);
    check("zm_rsp_new", rsp_new, 8'hDA);
    check("zm_value", value, 8'hDA);
    set_req(0, STD_MASK_OP_SET, 8'h01, 8'h00);
    set_req(1, STD_MASK_OP_SET, 8'h02, 8'h00);
    set_req(2, STD_MASK_OP_SET, 8'h04, 8'h00);
    #1;
    check("zm_ptr_wrap", req_ready, 3'b001);
    tick();
    check("pre_rst_value", value, 8'hDB);
    check("pre_rst_rsp_id", rsp_id, 0);

    // reset with a response pending and port 1 requesting
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid_before", rsp_valid, 1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_value", value, 8'hA5);
    check("mid_rst_rsp_id", rsp_id, 0);
    check("mid_rst_rsp_new", rsp_new, 0);
    set_req(0, STD_MASK_OP_SET, 8'h01, 8'h00);
    set_req(1, STD_MASK_OP_SET, 8'h02, 8'h00);
    set_req(2, STD_MASK_OP_SET, 8'h04, 8'h00);
    #1;
    check("mid_rst_ptr", req_ready, 3'b001);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/std_register_granular_arbiter.md
Name: std_register_granular_arbiter

Overview:
- Shares one bit-granular register among PORTS requesters.
- Each requester issues a masked read-modify-write operation (write, set, clear or toggle) over a valid/ready handshake.
- A round-robin arbiter picks one request per cycle. The block drives per-bit enable/next into an internal std_register_granular and returns the pre-update and post-update values on a single response channel.
- Used for shared status/control words: interrupt pending bits, lock bits and per-lane enables.

Parameters:
- CLOCK_INFO, 'b0, std_clock_info_t clock description, passed through to the storage register.
- T, logic, type of the shared register; W = $bits(T).
- RESET_VECTOR, 'b0, reset value of the shared register (type T).
- PORTS, 2, number of requesters; legal range 1..16; ID_W = max(1, $clog2(PORTS)).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  PORTS  per-requester request valid.
- req_ready  output  PORTS  per-requester accept; one-hot or zero.
- req_op  input  PORTS x 2  std_mask_op_t per requester.
- req_mask  input  PORTS x W  bit mask per requester.
- req_data  input  PORTS x W  write data per requester; used by WRITE only.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that was served.
- rsp_old  output  W  register value before the operation.
- rsp_new  output  W  register value after the operation.
- value  output  W  current register contents.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - value = RESET_VECTOR.
  - rsp_valid = 0; rsp_id = 0; rsp_old = 0; rsp_new = 0.
  - Round-robin pointer = 0.
  - A response pending at reset is dropped without a handshake.
- Arbitration:
  - grant = first i with req_valid[i], searching circularly from the pointer.
  - Grant is combinational from req_valid and the pointer only; it never depends on req_ready.
- Stall and accept:
  - can_issue = !rsp_valid || rsp_ready.
  - req_ready[i] = grant[i] && can_issue.
  - fire = |(req_valid & req_ready).
- Operation applied on fire, per bit k, to the granted port's op/mask/data:
  - enable[k] = mask[k].
  - WRITE: next[k] = data[k].
  - SET: next[k] = 1.
  - CLEAR: next[k] = 0.
  - TOGGLE: next[k] = !value[k].
  - Unmasked bits hold their value.
  - enable is all-zero when there is no fire.
- Update timing: value changes at the clk edge that sees fire, so the result is visible the following cycle. One operation per cycle at most; throughput is 1/cycle while rsp_ready stays high.
- Response, registered on fire:
  - rsp_valid = 1; rsp_id = granted index.
  - rsp_old = value before the edge; rsp_new = value after the edge.
  - Held stable until rsp_valid && rsp_ready.
  - rsp_ready high with a new fire in the same cycle: the next response is loaded directly with no bubble.
  - rsp_ready high with no fire: rsp_valid clears.
- Pointer:
  - On fire with grant i, pointer = (i+1) mod PORTS.
  - Without fire the pointer holds, including while stalled on the response.
- Boundary rules:
  - Zero mask: a legal transaction; value is unchanged and a response is still produced (rsp_old == rsp_new).
  - PORTS = 1: the arbiter degenerates to pass-through; rsp_id = 0.
  - req_valid dropped before acceptance: no effect; the grant moves to the next valid requester.
- No combinational path from rsp_ready to value.

Decomposition:
- std_pkg gains std_mask_op_t: 2-bit enum, STD_MASK_OP_WRITE = 0, SET = 1, CLEAR = 2, TOGGLE = 3.
- Sub-module std_round_robin_arbiter (parameter PORTS):
  - inputs: request vector, advance strobe;
  - output: one-hot grant;
  - contains the pointer register.
- Storage is an instance of std_register_granular with CLOCK_INFO, T and RESET_VECTOR passed through.

Test Plan:
Common setup: T = logic[7:0], PORTS = 3, RESET_VECTOR = 8'hA5.
- Reset, then idle -> value = A5, rsp_valid = 0, req_ready = 0.
- Port 1: WRITE, mask F0, data 3C, rsp_ready = 1 -> next cycle value = 35; response id = 1, old = A5, new = 35.
- Ports 0, 1, 2 all hold SET requests with masks 01, 02, 04 and rsp_ready = 1 -> grants in order 0, 1, 2 on consecutive cycles; value steps A5 -> A5 -> A7 -> A7; rsp_id sequence 0, 1, 2.
- Back-pressure: rsp_ready = 0 after the first fire (port 0, TOGGLE, mask FF) -> value = 5A; req_ready stays 0; the response is held (old = A5, new = 5A) until rsp_ready = 1, then port 1 fires in that same cycle.
- Port 2: CLEAR with mask 00 -> response with old == new == current value; pointer advances to 0.
- rst asserted while rsp_valid = 1 and a request is pending -> next cycle rsp_valid = 0, value = A5, pointer = 0, and the request is not applied.
